// File: rtl/lstm_seq_pkg.sv
// Shared types and helpers for the LSTM layer sequencer.
package lstm_seq_pkg;

  localparam int DEF_ADDR_W = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lstm_loop_cnt.sv
// Loop counter 0..MAX-1 with two running bases (cnt*STRIDE_A, cnt*STRIDE_B),
// so loop-scaled addresses need no multiplier. Bases return to zero on wrap.
module lstm_loop_cnt
  import lstm_seq_pkg::*;
#(
  parameter int MAX      = 2,
  parameter int STRIDE_A = 1,
  parameter int STRIDE_B = 1,
  parameter int W        = DEF_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] base_a,
  output logic [W-1:0] base_b,
  output logic         wrap
);

  localparam logic [W-1:0] LAST   = W'(MAX - 1);
  localparam logic [W-1:0] STEP_A = W'(STRIDE_A);
  localparam logic [W-1:0] STEP_B = W'(STRIDE_B);

  assign wrap = inc && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= '0;
      base_a <= '0;
      base_b <= '0;
    end else if (inc) begin
      if (cnt == LAST) begin
        cnt    <= '0;
        base_a <= '0;
        base_b <= '0;
      end else begin
        cnt    <= cnt + W'(1);
        base_a <= base_a + STEP_A;
        base_b <= base_b + STEP_B;
      end
    end
  end

endmodule

// File: rtl/lstm_layer_seq.sv
// Sequencer stepping one LSTM layer through TIMESTEP x N_CELL cells of K MACs.
// Optional LSTM_SEQ_PERF_EN adds a 32-bit cycle_cnt run-length counter.
module lstm_layer_seq
  import lstm_seq_pkg::*;
#(
  parameter int TIMESTEP = 7,
  parameter int N_IN     = 53,
  parameter int N_CELL   = 53,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              acc_x,
  output logic              acc_h,
  output logic              acc_clr,
  output logic [ADDR_W-1:0] addr_x,
  output logic [ADDR_W-1:0] rd_addr_h,
  output logic [ADDR_W-1:0] rd_addr_w,
  output logic [ADDR_W-1:0] rd_addr_u,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              wr_h,
  output logic              wr_c,
  output logic [ADDR_W-1:0] wr_addr_h,
  output logic [ADDR_W-1:0] wr_addr_c,
  output seq_state_e        state_dbg
`ifdef LSTM_SEQ_PERF_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);

  localparam int K = max_int(N_IN, N_CELL);
  localparam logic [ADDR_W-1:0] NIN_A    = ADDR_W'(N_IN);
  localparam logic [ADDR_W-1:0] NIN_M1   = ADDR_W'(N_IN - 1);
  localparam logic [ADDR_W-1:0] NCELL_A  = ADDR_W'(N_CELL);
  localparam logic [ADDR_W-1:0] NCELL_M1 = ADDR_W'(N_CELL - 1);

  if (((TIMESTEP + 1) * N_CELL > (2 ** ADDR_W)) || (TIMESTEP * N_IN > (2 ** ADDR_W))) begin : g_addr_chk
    $error("lstm_layer_seq: ADDR_W too narrow for TIMESTEP/N_IN/N_CELL");
  end

  seq_state_e        state, state_nx;
  logic              start_acc, inc_k, inc_j, inc_t;
  logic              wrap_k, wrap_j, wrap_t;
  logic [ADDR_W-1:0] k, j, j_nin, j_ncell, t_nin, t_ncell;
  logic [ADDR_W-1:0] k_base_a_unused, k_base_b_unused, t_cnt_unused;
  logic [ADDR_W-1:0] k_x, k_h, wr_addr_nx;

  assign start_acc = (state == IDLE) && start;
  assign inc_k     = (state == MAC);
  assign inc_j     = (state == WRITE);
  assign inc_t     = inc_j && wrap_j;

  lstm_loop_cnt #(.MAX(K), .STRIDE_A(0), .STRIDE_B(0), .W(ADDR_W)) u_k_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(inc_k),
    .cnt(k), .base_a(k_base_a_unused), .base_b(k_base_b_unused), .wrap(wrap_k)
  );

  lstm_loop_cnt #(.MAX(N_CELL), .STRIDE_A(N_IN), .STRIDE_B(N_CELL), .W(ADDR_W)) u_j_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(inc_j),
    .cnt(j), .base_a(j_nin), .base_b(j_ncell), .wrap(wrap_j)
  );

  lstm_loop_cnt #(.MAX(TIMESTEP), .STRIDE_A(N_IN), .STRIDE_B(N_CELL), .W(ADDR_W)) u_t_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(inc_t),
    .cnt(t_cnt_unused), .base_a(t_nin), .base_b(t_ncell), .wrap(wrap_t)
  );

  // Once a path's index runs past its length the address parks on the last element.
  assign k_x        = (k < NIN_A) ? k : NIN_M1;
  assign k_h        = (k < NCELL_A) ? k : NCELL_M1;
  assign wr_addr_nx = t_ncell + NCELL_A + j;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CLEAR;
      CLEAR:   state_nx = MAC;
      MAC:     if (wrap_k) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = (wrap_j && wrap_t) ? DONE : CLEAR;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Strobes and addresses are registered from the current state, one cycle behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_x     <= 1'b0;
      acc_h     <= 1'b0;
      acc_clr   <= 1'b0;
      wr_h      <= 1'b0;
      wr_c      <= 1'b0;
      addr_x    <= '0;
      rd_addr_h <= '0;
      rd_addr_w <= '0;
      rd_addr_u <= '0;
      rd_addr_b <= '0;
      wr_addr_h <= '0;
      wr_addr_c <= '0;
    end else begin
      busy    <= (state != IDLE) && (state != DONE);
      done    <= (state == DONE);
      acc_clr <= (state == CLEAR);
      acc_x   <= (state == MAC) && (k < NIN_A);
      acc_h   <= (state == MAC) && (k < NCELL_A);
      wr_h    <= (state == WRITE);
      wr_c    <= (state == WRITE);
      if (state == CLEAR) rd_addr_b <= j;
      if (state == MAC) begin
        addr_x    <= t_nin + k_x;
        rd_addr_w <= j_nin + k_x;
        rd_addr_u <= j_ncell + k_h;
        rd_addr_h <= t_ncell + k_h;
      end
      if (state == WRITE) begin
        wr_addr_h <= wr_addr_nx;
        wr_addr_c <= wr_addr_nx;
      end
    end
  end

`ifdef LSTM_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst || start_acc)  cycle_cnt <= '0;
    else if (state != IDLE) cycle_cnt <= cycle_cnt + 32'd1;
  end
`endif

endmodule
